// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch front end of the 5-stage core.
// Defines the IF/ID slot layout, the fetch FSM states and the fetch fault check.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        fault;
  } if_id_t;

  // A fetch faults when it is misaligned or its word index lies past the end of imem.
  function automatic logic fetch_fault(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard controls, redirect, imem port and the IF/ID outputs.
// master = fetch stage, slave = surrounding core (hazard unit, EX, decode, imem).
interface fetch_stage_if;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        halt_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        fault_d;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    input  stall_f, stall_d, flush_d, pc_src_e, pc_target_e, halt_req, imem_rdata,
    output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fault_d, halted, fetch_count
  );

  modport slave (
    output stall_f, stall_d, flush_d, pc_src_e, pc_target_e, halt_req, imem_rdata,
    input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fault_d, halted, fetch_count
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: one-cycle capture, flush beats stall, stall holds every field.
// A bubble forces NOP/invalid/no-fault but keeps the previous pc fields.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush_i,
  input  logic   stall_i,
  input  if_id_t slot_i,
  output if_id_t slot_o
);

  if_id_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (flush_i) begin
      slot_d.instr = NOP_INSTR;
      slot_d.valid = 1'b0;
      slot_d.fault = 1'b0;
    end else if (!stall_i) begin
      slot_d = slot_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q.instr    <= NOP_INSTR;
      slot_q.pc       <= '0;
      slot_q.pc_plus4 <= '0;
      slot_q.valid    <= 1'b0;
      slot_q.fault    <= 1'b0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: registered PC drives imem, returned word lands in IF/ID one cycle later.
// Honours stall_f/stall_d/flush_d from the hazard unit; halt_req freezes fetch until reset.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 64
) (
  input logic            clk,
  input logic            rst_n,
  fetch_stage_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_f_q, pc_f_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  pc_plus4;
  logic         ifid_flush;
  logic         ifid_stall;
  logic         fault;
  logic         valid_load;
  if_id_t       load_slot;
  if_id_t       ifid_slot;

  assign pc_plus4 = pc_f_q + 32'd4;

  // Halt outranks a redirect: the PC stays where the halting fetch left it.
  always_comb begin
    state_d    = state_q;
    pc_f_d     = pc_f_q;
    ifid_flush = 1'b0;
    ifid_stall = 1'b0;
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        ifid_flush = 1'b1;
      end
      RUN: begin
        ifid_flush = bus.flush_d | (bus.halt_req & ~bus.stall_d);
        ifid_stall = bus.stall_d;
        if (bus.halt_req) begin
          state_d = HALT;
        end else if (bus.pc_src_e) begin
          pc_f_d = bus.pc_target_e;
        end else if (!bus.stall_f) begin
          pc_f_d = pc_plus4;
        end
      end
      HALT: begin
        ifid_flush = bus.flush_d | ~bus.stall_d;
        ifid_stall = bus.stall_d;
      end
      default: begin
        state_d    = BOOT;
        ifid_flush = 1'b1;
      end
    endcase
  end

  assign fault = fetch_fault(pc_f_q, IMEM_DEPTH);

  always_comb begin
    load_slot.pc       = pc_f_q;
    load_slot.pc_plus4 = pc_plus4;
    load_slot.instr    = fault ? NOP_INSTR : bus.imem_rdata;
    load_slot.valid    = ~fault;
    load_slot.fault    = fault;
  end

  assign valid_load = ~ifid_flush & ~ifid_stall & load_slot.valid;
  assign count_d    = (valid_load && (count_q != 32'hFFFF_FFFF)) ? count_q + 32'd1 : count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_f_q  <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_f_q  <= pc_f_d;
      count_q <= count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (ifid_flush),
    .stall_i (ifid_stall),
    .slot_i  (load_slot),
    .slot_o  (ifid_slot)
  );

  assign bus.imem_addr   = pc_f_q;
  assign bus.instr_d     = ifid_slot.instr;
  assign bus.pc_d        = ifid_slot.pc;
  assign bus.pc_plus4_d  = ifid_slot.pc_plus4;
  assign bus.valid_d     = ifid_slot.valid;
  assign bus.fault_d     = ifid_slot.fault;
  assign bus.halted      = (state_q == HALT);
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stalls, redirect, faults, halt, saturation.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  logic [31:0] mem [64];
  int n_tests;
  int n_fail;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_rdata = (bus.imem_addr < 32'd256) ? mem[bus.imem_addr[7:2]] : 32'hDEAD_BEEF;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall_f = 0; bus.stall_d = 0; bus.flush_d = 0;
    bus.pc_src_e = 0; bus.pc_target_e = 32'h0; bus.halt_req = 0;
  endtask

  task automatic check_reset_values(input string tag);
    n_tests++;
    if ({bus.imem_addr, bus.instr_d, bus.pc_d, bus.pc_plus4_d} !== {32'h0, 32'h0000_0013, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL %s_regs got addr=%h instr=%h pc=%h pc4=%h want 0/00000013/0/0", tag,
               bus.imem_addr, bus.instr_d, bus.pc_d, bus.pc_plus4_d);
    end
    n_tests++;
    if ({bus.valid_d, bus.fault_d, bus.halted, bus.fetch_count} !== {3'b000, 32'h0}) begin
      n_fail++;
      $display("FAIL %s_flags got v=%b f=%b h=%b cnt=%h want 0 0 0 0", tag,
               bus.valid_d, bus.fault_d, bus.halted, bus.fetch_count);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_reset_values("reset");
    #5 rst_n = 1'b1;
    step();
    n_tests++;
    if ({bus.imem_addr, bus.valid_d, bus.instr_d} !== {32'h0, 1'b0, 32'h0000_0013}) begin
      n_fail++;
      $display("FAIL boot_edge got addr=%h v=%b instr=%h want 0 0 00000013", bus.imem_addr, bus.valid_d, bus.instr_d);
    end
  endtask

  task automatic test_first_fetch();
    step();
    n_tests++;
    if ({bus.instr_d, bus.pc_d, bus.valid_d, bus.imem_addr, bus.fetch_count} !== {32'h0050_0093, 32'h0, 1'b1, 32'h4, 32'd1}) begin
      n_fail++;
      $display("FAIL first_fetch got instr=%h pc=%h v=%b addr=%h cnt=%0d want 00500093 0 1 4 1",
               bus.instr_d, bus.pc_d, bus.valid_d, bus.imem_addr, bus.fetch_count);
    end
    step();
    n_tests++;
    if ({bus.instr_d, bus.pc_d, bus.pc_plus4_d, bus.imem_addr, bus.fetch_count} !== {32'h0010_0113, 32'h4, 32'h8, 32'h8, 32'd2}) begin
      n_fail++;
      $display("FAIL second_fetch got instr=%h pc=%h pc4=%h addr=%h cnt=%0d want 00100113 4 8 8 2",
               bus.instr_d, bus.pc_d, bus.pc_plus4_d, bus.imem_addr, bus.fetch_count);
    end
  endtask

  task automatic test_stall();
    bus.stall_f = 1; bus.stall_d = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({bus.imem_addr, bus.instr_d, bus.pc_d, bus.valid_d, bus.fetch_count} !== {32'h8, 32'h0010_0113, 32'h4, 1'b1, 32'd2}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got addr=%h instr=%h pc=%h v=%b cnt=%0d want 8 00100113 4 1 2",
                 i, bus.imem_addr, bus.instr_d, bus.pc_d, bus.valid_d, bus.fetch_count);
      end
    end
    clear_inputs();
    step();
    n_tests++;
    if ({bus.instr_d, bus.pc_d, bus.imem_addr, bus.fetch_count} !== {32'hA000_0008, 32'h8, 32'hC, 32'd3}) begin
      n_fail++;
      $display("FAIL stall_release got instr=%h pc=%h addr=%h cnt=%0d want a0000008 8 c 3",
               bus.instr_d, bus.pc_d, bus.imem_addr, bus.fetch_count);
    end
  endtask

  task automatic test_redirect();
    bus.pc_src_e = 1; bus.pc_target_e = 32'h20; bus.flush_d = 1; bus.stall_f = 1; bus.stall_d = 1;
    step();
    n_tests++;
    if ({bus.imem_addr, bus.valid_d, bus.instr_d, bus.pc_d, bus.fetch_count} !== {32'h20, 1'b0, 32'h0000_0013, 32'h8, 32'd3}) begin
      n_fail++;
      $display("FAIL redirect_flush got addr=%h v=%b instr=%h pc=%h cnt=%0d want 20 0 00000013 8 3",
               bus.imem_addr, bus.valid_d, bus.instr_d, bus.pc_d, bus.fetch_count);
    end
    clear_inputs();
    step();
    n_tests++;
    if ({bus.pc_d, bus.valid_d, bus.instr_d, bus.imem_addr, bus.fetch_count} !== {32'h20, 1'b1, 32'hA000_0020, 32'h24, 32'd4}) begin
      n_fail++;
      $display("FAIL redirect_target got pc=%h v=%b instr=%h addr=%h cnt=%0d want 20 1 a0000020 24 4",
               bus.pc_d, bus.valid_d, bus.instr_d, bus.imem_addr, bus.fetch_count);
    end
  endtask

  task automatic test_fault();
    bus.pc_src_e = 1; bus.pc_target_e = 32'h22;
    step();
    n_tests++;
    if ({bus.imem_addr, bus.instr_d, bus.valid_d, bus.fetch_count} !== {32'h22, 32'hA000_0024, 1'b1, 32'd5}) begin
      n_fail++;
      $display("FAIL pre_misalign got addr=%h instr=%h v=%b cnt=%0d want 22 a0000024 1 5",
               bus.imem_addr, bus.instr_d, bus.valid_d, bus.fetch_count);
    end
    clear_inputs();
    step();
    n_tests++;
    if ({bus.fault_d, bus.valid_d, bus.instr_d, bus.pc_d, bus.pc_plus4_d, bus.imem_addr} !== {2'b10, 32'h0000_0013, 32'h22, 32'h26, 32'h26}) begin
      n_fail++;
      $display("FAIL misalign_fault got f=%b v=%b instr=%h pc=%h pc4=%h addr=%h want 1 0 00000013 22 26 26",
               bus.fault_d, bus.valid_d, bus.instr_d, bus.pc_d, bus.pc_plus4_d, bus.imem_addr);
    end
    bus.pc_src_e = 1; bus.pc_target_e = 32'h100;
    step();
    clear_inputs();
    step();
    n_tests++;
    if ({bus.fault_d, bus.valid_d, bus.instr_d, bus.pc_d, bus.imem_addr, bus.fetch_count} !== {2'b10, 32'h0000_0013, 32'h100, 32'h104, 32'd5}) begin
      n_fail++;
      $display("FAIL range_fault got f=%b v=%b instr=%h pc=%h addr=%h cnt=%0d want 1 0 00000013 100 104 5",
               bus.fault_d, bus.valid_d, bus.instr_d, bus.pc_d, bus.imem_addr, bus.fetch_count);
    end
  endtask

  task automatic test_halt();
    bus.pc_src_e = 1; bus.pc_target_e = 32'h10; bus.flush_d = 1;
    step();
    clear_inputs();
    bus.halt_req = 1; bus.pc_src_e = 1; bus.pc_target_e = 32'h30;
    step();
    n_tests++;
    if ({bus.halted, bus.imem_addr, bus.valid_d, bus.fault_d, bus.instr_d, bus.fetch_count} !== {1'b1, 32'h10, 2'b00, 32'h0000_0013, 32'd5}) begin
      n_fail++;
      $display("FAIL halt_entry got h=%b addr=%h v=%b f=%b instr=%h cnt=%0d want 1 10 0 0 00000013 5",
               bus.halted, bus.imem_addr, bus.valid_d, bus.fault_d, bus.instr_d, bus.fetch_count);
    end
    clear_inputs();
    bus.pc_src_e = 1; bus.pc_target_e = 32'h40; bus.halt_req = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if ({bus.halted, bus.imem_addr, bus.valid_d, bus.fetch_count} !== {1'b1, 32'h10, 1'b0, 32'd5}) begin
        n_fail++;
        $display("FAIL halt_ignore[%0d] got h=%b addr=%h v=%b cnt=%0d want 1 10 0 5",
                 i, bus.halted, bus.imem_addr, bus.valid_d, bus.fetch_count);
      end
    end
    clear_inputs();
    bus.stall_d = 1;
    step();
    n_tests++;
    if ({bus.halted, bus.valid_d, bus.instr_d, bus.imem_addr} !== {2'b10, 32'h0000_0013, 32'h10}) begin
      n_fail++;
      $display("FAIL halt_stall got h=%b v=%b instr=%h addr=%h want 1 0 00000013 10",
               bus.halted, bus.valid_d, bus.instr_d, bus.imem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midhalt_reset");
    clear_inputs();
    #3 rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    step();
    step();
    n_tests++;
    if ({bus.instr_d, bus.valid_d, bus.fetch_count} !== {32'h0050_0093, 1'b1, 32'd1}) begin
      n_fail++;
      $display("FAIL refetch_after_reset got instr=%h v=%b cnt=%0d want 00500093 1 1",
               bus.instr_d, bus.valid_d, bus.fetch_count);
    end
    bus.stall_f = 1; bus.stall_d = 1;
    force dut.count_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.count_q;
    step();
    n_tests++;
    if (bus.fetch_count !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL preload_hold got cnt=%h want fffffffe", bus.fetch_count);
    end
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({bus.valid_d, bus.fetch_count} !== {1'b1, 32'hFFFF_FFFF}) begin
        n_fail++;
        $display("FAIL saturate[%0d] got v=%b cnt=%h want 1 ffffffff", i, bus.valid_d, bus.fetch_count);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | (i << 2);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect();
    test_fault();
    test_halt();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipelined RISC-V core. Holds the program counter, drives the byte address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. It handles hazard-unit stalls and flushes, branch/jump redirects from EX, halt requests, and out-of-range or misaligned fetch detection.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_DEPTH, 64, instruction memory depth in 32-bit words; used for range check.

Ports:
- clk  in  1  clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- stall_f  in  1  hold PC.
- stall_d  in  1  hold IF/ID register.
- flush_d  in  1  load a bubble into IF/ID.
- pc_src_e  in  1  redirect taken in EX.
- pc_target_e  in  32  redirect target.
- halt_req  in  1  stop fetching (from decode, ecall/ebreak).
- imem_addr  out  32  byte address to instruction memory (= pc_f).
- imem_rdata  in  32  instruction word, combinational from imem_addr.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc_plus4_d  out  32  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real instruction.
- fault_d  out  1  IF/ID slot came from a faulting fetch.
- halted  out  1  FSM in HALT.
- fetch_count  out  32  count of valid instructions loaded into IF/ID.

## Operation
- FSM states: BOOT, RUN, HALT. Reset enters BOOT.
- BOOT: lasts one cycle. pc_f holds RESET_PC and IF/ID is loaded with a bubble. Next state is RUN.
- RUN, next-PC priority:
  - pc_src_e: pc_f <= pc_target_e.
  - else stall_f: pc_f holds.
  - else pc_f <= pc_f + 4, modulo 2^32 with wrap permitted.
- RUN, IF/ID priority:
  - flush_d: bubble.
  - else stall_d: hold all IF/ID fields.
  - else load {imem_rdata, pc_f, pc_f+4, valid=1, fault=0}.
- Bubble means instr_d=NOP (32'h0000_0013), valid_d=0, fault_d=0. pc_d and pc_plus4_d hold their previous values.
- Fault: imem_addr[1:0]!=0 or imem_addr[31:2] >= IMEM_DEPTH. On a non-stalled, non-flushed load, a fault gives instr_d=NOP, valid_d=0, fault_d=1, and pc_d=faulting PC. The PC still advances normally.
- halt_req in RUN:
  - Next state is HALT and PC freezes.
  - The current cycle's IF/ID load is replaced by a bubble unless stall_d is set.
- HALT: PC frozen. pc_src_e, stall_f and halt_req are ignored. IF/ID loads a bubble whenever stall_d=0. The only exit is reset.
- fetch_count increments by 1 on every IF/ID load with valid=1 and saturates at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - pc_f / imem_addr = RESET_PC.
  - instr_d = NOP; pc_d = 0; pc_plus4_d = 0.
  - valid_d = 0; fault_d = 0; halted = 0; fetch_count = 0.
- Assertion of rst_n takes effect immediately, mid-operation included. All state is lost.
- imem_addr is a registered output with no combinational path from any input.
- Fetch latency: the word at imem_addr in cycle n appears on instr_d in cycle n+1.
- First valid instruction after reset release:
  - Edge 1 (BOOT): IF/ID loads a bubble; pc_f stays RESET_PC.
  - Edge 2: instr_d = mem[RESET_PC] with valid_d=1; pc_f becomes RESET_PC+4.
- Redirect: pc_src_e at cycle n gives imem_addr=pc_target_e at n+1. The flush of the wrong-path IF/ID slot is the hazard unit's job via flush_d.
- pc_src_e together with stall_f: redirect wins.
- flush_d together with stall_d: flush wins.
- halt_req together with pc_src_e: halt wins and the PC freezes at its current value.
- halted rises on the edge after halt_req is sampled in RUN.

## Structure
- riscv_pkg holds:
  - NOP_INSTR = 32'h0000_0013.
  - fetch_state_e enum {BOOT, RUN, HALT}.
  - if_id_t struct {instr, pc, pc_plus4, valid, fault}.
- One sub-module, if_id_reg: the IF/ID register with stall/flush priority and bubble insertion, taking an if_id_t in and out.
- The PC, FSM, fault check and counter live in fetch_stage.

## Test plan
- Reset release, memory loaded with 0x00500093, 0x00100113, ...: cycle 2 gives instr_d=0x00500093, pc_d=0, valid_d=1; cycle 3 gives instr_d=0x00100113, pc_d=4.
- stall_f=stall_d=1 for 3 cycles at pc_f=0x8: imem_addr stays 0x8, IF/ID is held, fetch_count does not change. Release: sequential fetch resumes from 0x8.
- pc_src_e=1, pc_target_e=0x20, flush_d=1 in the same cycle: the next cycle has imem_addr=0x20 and valid_d=0; the cycle after has pc_d=0x20, valid_d=1.
- pc_target_e=0x22 (misaligned), then pc_target_e=0x100 (index 64, out of range): each gives fault_d=1, valid_d=0, instr_d=NOP, pc_d equal to the faulting address.
- halt_req at pc_f=0x10 with pc_src_e=1 in the same cycle: halted=1 next cycle, imem_addr frozen at 0x10, IF/ID bubbles only, later pc_src_e ignored. rst_n low mid-halt returns every output to its reset value immediately.
- fetch_count preloaded near saturation (force to 32'hFFFF_FFFE) followed by 3 valid loads: fetch_count = 32'hFFFF_FFFF and does not wrap.
